// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the adder arbiter slice.
package adder_arb_pkg;

    localparam int unsigned DEF_N    = 64;
    localparam int unsigned DEF_NREQ = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef logic [DEF_N-1:0] operand_t;

endpackage

// File: rtl/adder.sv
// Plain N-bit adder; carry-out is dropped so sums wrap modulo 2^N.
module adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    logic           found;
    logic [IDW-1:0] idx;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NREQ requesters, result held in a
// single tagged output register with valid/ready toward the consumer.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0][N-1:0]   req_a,
    input  logic [NREQ-1:0][N-1:0]   req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [N-1:0]             rsp_sum,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N-1:0]    sum_q, sum_d;
    logic [IDW-1:0]  id_q, id_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic [N-1:0]    add_sum;
    logic            can_accept;
    logic            fire;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    adder #(
        .N (N)
    ) u_adder (
        .a_i   (req_a[arb_idx]),
        .b_i   (req_b[arb_idx]),
        .sum_o (add_sum)
    );

    // A consumer pop in the same cycle frees the register, so accept back-to-back.
    assign can_accept = (state_q == EMPTY) | rsp_ready;
    assign fire       = can_accept & (|req_valid);
    assign req_ready  = fire ? arb_gnt : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sum_d    = sum_q;
        id_d     = id_q;
        unique case (state_q)
            EMPTY: if (fire) state_d = FULL;
            FULL:  if (!fire && rsp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (fire) begin
            sum_d    = add_sum;
            id_d     = arb_idx;
            rr_ptr_d = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            sum_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sum_q    <= sum_d;
            id_q     <= id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = rsp_valid & ~rsp_ready;

endmodule
